iobus_timer: RTL and testbench
==============================

IOBUS_TIMER -- requirements
Module: iobus_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1100_0100, base of the 32-byte register window; SHALL be 32-byte aligned.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 iobus_addr  input  32  CPU IO bus address.
REQ-005 iobus_out  input  32  CPU IO bus write data.
REQ-006 iobus_wr  input  1  CPU IO bus write strobe, one cycle per store.
REQ-007 iobus_in  output  32  read data returned to the CPU.
REQ-008 intrpt  output  1  level interrupt request to the CPU.

Function
REQ-009 Block selected when iobus_addr[31:5] == BASE_ADDR[31:5]; word offset is iobus_addr[4:2]; iobus_addr[1:0] ignored.
REQ-010 Register map by offset: 0 CTRL, 1 PRESCALE, 2 COMPARE, 3 COUNT, 4 STATUS; offsets 5-7 unmapped.
REQ-011 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits 31:3 read 0 and ignore writes.
REQ-012 PRESCALE: 16-bit R/W in bits 15:0, upper bits read 0.
REQ-013 COMPARE: 32-bit R/W; COUNT: 32-bit R/W, read returns live counter.
REQ-014 STATUS: bit0 PENDING, bit1 OVERRUN; write 1 clears the bit (W1C), write 0 leaves it unchanged.
REQ-015 Write takes effect on the rising edge where iobus_wr=1 and block is selected; writes to unmapped offsets or unselected addresses SHALL change no state.
REQ-016 iobus_in SHALL be combinational from iobus_addr and registered state, same cycle, no wait states; unselected or unmapped addresses SHALL return 32'h0.
REQ-017 Internal 16-bit prescale counter PS: while EN=1, PS increments each cycle; when PS == PRESCALE, PS wraps to 0 and a one-cycle TICK is generated.
REQ-018 PRESCALE=0 SHALL give TICK every cycle while EN=1.
REQ-019 While EN=0, PS and COUNT SHALL hold and no TICK SHALL occur.
REQ-020 On TICK with COUNT != COMPARE, COUNT increments by 1 (mod 2^32).
REQ-021 On TICK with COUNT == COMPARE: COUNT <= 0, PENDING <= 1; OVERRUN <= 1 if PENDING already 1; EN <= 0 if AUTO_RELOAD=0.
REQ-022 COMPARE=0 with PRESCALE=0 SHALL match on every TICK.
REQ-023 Write to CTRL that changes EN 0->1 SHALL clear PS to 0.
REQ-024 Write to PRESCALE SHALL clear PS to 0 in the same edge.
REQ-025 Write to COUNT in the same cycle as a TICK: written value wins, no match evaluated that cycle.
REQ-026 Write to CTRL in the same cycle as a match with AUTO_RELOAD=0: written EN value wins.
REQ-027 W1C of PENDING in the same cycle as a match: set wins, PENDING stays 1; same rule for OVERRUN.
REQ-028 intrpt = PENDING & IRQ_EN, glitch-free AND of two flops, held until PENDING cleared or IRQ_EN written 0.
REQ-029 Match latency: PENDING and intrpt SHALL assert on the same edge where COUNT wraps to 0.

Reset
REQ-030 rst=1 SHALL asynchronously clear CTRL, PRESCALE, COMPARE, COUNT, PS, PENDING, OVERRUN to 0.
REQ-031 During and after reset until first write, intrpt=0 and iobus_in=0 for every address except COMPARE/COUNT/etc., which read 0.
REQ-032 Reset asserted mid-count SHALL abort counting immediately; no TICK or match SHALL occur on the deassertion edge.

Verification
REQ-033 Write PRESCALE=0, COMPARE=3, CTRL=3'b111 -> COUNT reads 1,2,3 on successive cycles, then 0 with intrpt=1 on the 4th edge; repeats every 4 cycles.
REQ-034 PRESCALE=4, COMPARE=1, CTRL=3'b101 -> match after 10 cycles; EN reads 0 afterwards; COUNT holds 0; intrpt=1 until STATUS write 32'h1 clears it.
REQ-035 Leave PENDING set across a second match -> STATUS reads 32'h3; write 32'h2 -> reads 32'h1.
REQ-036 Issue STATUS W1C 32'h1 on the exact match edge -> PENDING remains 1, intrpt remains 1.
REQ-037 Read BASE_ADDR+0x14 and address 32'h1100_0000 -> iobus_in=0; write to them -> all registers unchanged.
REQ-038 Assert rst with COUNT=7, PENDING=1 -> intrpt=0 and COUNT=0 before next clock edge; no activity after release until CTRL written.

Source files
------------

// File: rtl/iobus_timer.sv
// Memory-mapped prescaled compare timer on the CPU IO bus.
// CTRL/PRESCALE/COMPARE/COUNT/STATUS window with a level interrupt on compare match.
module iobus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] iobus_in,
    output logic        intrpt
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic        en;
    logic        auto_reload;
    logic        irq_en;
    logic [15:0] prescale;
    logic [31:0] compare;
    logic [31:0] count;
    logic [15:0] ps;
    logic        pending;
    logic        overrun;

    logic        sel;
    logic [2:0]  off;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_compare;
    logic        wr_count;
    logic        wr_status;
    logic        tick;
    logic        match;
    logic [1:0]  unused_addr_bits;

    assign unused_addr_bits = iobus_addr[1:0];

    assign sel         = (iobus_addr[31:5] == BASE_ADDR[31:5]);
    assign off         = iobus_addr[4:2];
    assign wr_ctrl     = iobus_wr && sel && (off == OFF_CTRL);
    assign wr_prescale = iobus_wr && sel && (off == OFF_PRESCALE);
    assign wr_compare  = iobus_wr && sel && (off == OFF_COMPARE);
    assign wr_count    = iobus_wr && sel && (off == OFF_COUNT);
    assign wr_status   = iobus_wr && sel && (off == OFF_STATUS);

    assign tick  = en && (ps == prescale);
    // A CPU store to COUNT overrides the tick, so no match is judged that cycle.
    assign match = tick && !wr_count && (count == compare);

    assign intrpt = pending && irq_en;

    always_comb begin
        iobus_in = 32'h0;
        if (sel) begin
            case (off)
                OFF_CTRL:     iobus_in = {29'h0, irq_en, auto_reload, en};
                OFF_PRESCALE: iobus_in = {16'h0, prescale};
                OFF_COMPARE:  iobus_in = compare;
                OFF_COUNT:    iobus_in = count;
                OFF_STATUS:   iobus_in = {30'h0, overrun, pending};
                default:      iobus_in = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= 16'h0;
            compare     <= 32'h0;
            count       <= 32'h0;
            ps          <= 16'h0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Restarting the timer or changing the divide ratio realigns the prescaler.
            if (wr_prescale || (wr_ctrl && !en && iobus_out[0]))
                ps <= 16'h0;
            else if (tick)
                ps <= 16'h0;
            else if (en)
                ps <= ps + 16'd1;

            if (wr_count)
                count <= iobus_out;
            else if (match)
                count <= 32'h0;
            else if (tick)
                count <= count + 32'd1;

            if (wr_ctrl) begin
                en          <= iobus_out[0];
                auto_reload <= iobus_out[1];
                irq_en      <= iobus_out[2];
            end else if (match && !auto_reload) begin
                en <= 1'b0;
            end

            if (wr_prescale)
                prescale <= iobus_out[15:0];
            if (wr_compare)
                compare <= iobus_out;

            // A match beats a simultaneous W1C so no event is silently lost.
            if (match)
                pending <= 1'b1;
            else if (wr_status && iobus_out[0])
                pending <= 1'b0;

            if (match && pending)
                overrun <= 1'b1;
            else if (wr_status && iobus_out[1])
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iobus_timer.sv
// Self-checking bench for iobus_timer: directed scenarios plus random bus traffic
// compared against an event-level reference model of the timer.
module tb_iobus_timer;

    localparam logic [31:0] BASE = 32'h1100_0100;

    logic        clk;
    logic        rst;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] iobus_in;
    logic        intrpt;

    iobus_timer #(.BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .iobus_addr (iobus_addr),
        .iobus_out  (iobus_out),
        .iobus_wr   (iobus_wr),
        .iobus_in   (iobus_in),
        .intrpt     (intrpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd_obs;
    logic        irq_obs;

    // reference model state
    logic        m_en, m_ar, m_ie, m_pend, m_ovr;
    logic [15:0] m_pre, m_ps;
    logic [31:0] m_cmp, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_ovr = 0;
        m_pre = 0; m_ps = 0; m_cmp = 0; m_cnt = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:5] != BASE[31:5]) return 32'h0;
        case (a[4:2])
            3'd0: return {29'h0, m_ie, m_ar, m_en};
            3'd1: return {16'h0, m_pre};
            3'd2: return m_cmp;
            3'd3: return m_cnt;
            3'd4: return {30'h0, m_ovr, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    // One clock of timer behaviour: time passes first, then bus writes override.
    function automatic void model_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic       hit = wr && (a[31:5] == BASE[31:5]);
        logic [2:0] o = a[4:2];
        logic       was_en = m_en;
        logic       was_pend = m_pend;
        logic       ticked = 1'b0;
        logic       matched = 1'b0;
        if (m_en) begin
            if (m_ps == m_pre) begin ticked = 1'b1; m_ps = 16'h0; end
            else m_ps = m_ps + 16'd1;
        end
        if (ticked && !(hit && o == 3'd3)) begin
            if (m_cnt == m_cmp) begin matched = 1'b1; m_cnt = 32'h0; end
            else m_cnt = m_cnt + 32'd1;
        end
        if (hit && o == 3'd4) begin
            if (d[0]) m_pend = 1'b0;
            if (d[1]) m_ovr = 1'b0;
        end
        if (matched) begin
            if (was_pend) m_ovr = 1'b1;
            m_pend = 1'b1;
            if (!m_ar) m_en = 1'b0;
        end
        if (hit) begin
            case (o)
                3'd0: begin
                    if (d[0] && !was_en) m_ps = 16'h0;
                    m_en = d[0]; m_ar = d[1]; m_ie = d[2];
                end
                3'd1: begin m_pre = d[15:0]; m_ps = 16'h0; end
                3'd2: m_cmp = d;
                3'd3: m_cnt = d;
                default: ;
            endcase
        end
    endfunction

    task automatic do_cycle(input logic wr, input logic [31:0] a, input logic [31:0] d);
        iobus_wr   = wr;
        iobus_addr = a;
        iobus_out  = d;
        @(negedge clk);
        rd_obs  = iobus_in;
        irq_obs = intrpt;
        chk("model_read", rd_obs, model_read(a));
        chk("model_intrpt", {31'h0, irq_obs}, {31'h0, m_pend & m_ie});
        @(posedge clk);
        model_step(wr, a, d);
        #1;
        iobus_wr = 1'b0;
    endtask

    task automatic wr_reg(input int o, input logic [31:0] d);
        do_cycle(1'b1, BASE + 32'(o * 4), d);
    endtask

    task automatic rd_reg(input int o);
        do_cycle(1'b0, BASE + 32'(o * 4), 32'h0);
    endtask

    logic [31:0] exp_cnt [9];
    logic        exp_irq [9];
    logic [31:0] exp_regs [5];

    initial begin
        rst = 1'b1;
        iobus_wr = 1'b0;
        iobus_addr = BASE;
        iobus_out = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            iobus_addr = BASE + 32'(i * 4);
            #1;
            chk("reset_read", iobus_in, 32'h0);
        end
        chk("reset_intrpt", {31'h0, intrpt}, 32'h0);
        rst = 1'b0;

        // free-running compare at full rate
        wr_reg(1, 32'h0);
        wr_reg(2, 32'd3);
        wr_reg(0, 32'h7);
        exp_cnt = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        exp_irq = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            rd_reg(3);
            chk("auto_count", rd_obs, exp_cnt[i]);
            chk("auto_intrpt", {31'h0, irq_obs}, {31'h0, exp_irq[i]});
        end
        wr_reg(0, 32'h0);
        wr_reg(4, 32'h3);
        wr_reg(3, 32'h0);

        // one-shot with prescale 4
        wr_reg(1, 32'd4);
        wr_reg(2, 32'd1);
        wr_reg(0, 32'h5);
        for (int i = 0; i < 10; i++) rd_reg(4);
        chk("oneshot_pre_status", rd_obs, 32'h0);
        chk("oneshot_pre_intrpt", {31'h0, irq_obs}, 32'h0);
        rd_reg(4);
        chk("oneshot_status", rd_obs, 32'h1);
        chk("oneshot_intrpt", {31'h0, irq_obs}, 32'h1);
        rd_reg(0);
        chk("oneshot_ctrl", rd_obs, 32'h4);
        for (int i = 0; i < 3; i++) begin
            rd_reg(3);
            chk("oneshot_count_hold", rd_obs, 32'h0);
        end
        wr_reg(4, 32'h1);
        rd_reg(4);
        chk("oneshot_cleared", rd_obs, 32'h0);
        chk("oneshot_irq_cleared", {31'h0, irq_obs}, 32'h0);

        // overrun from back-to-back matches
        wr_reg(1, 32'h0);
        wr_reg(2, 32'h0);
        wr_reg(3, 32'h0);
        wr_reg(0, 32'h7);
        rd_reg(4);
        rd_reg(4);
        wr_reg(0, 32'h0);
        rd_reg(4);
        chk("overrun_status", rd_obs, 32'h3);
        wr_reg(4, 32'h2);
        rd_reg(4);
        chk("overrun_clear", rd_obs, 32'h1);

        // W1C racing a match
        wr_reg(4, 32'h3);
        wr_reg(3, 32'h0);
        wr_reg(2, 32'd2);
        wr_reg(0, 32'h7);
        rd_reg(3);
        rd_reg(3);
        wr_reg(4, 32'h1);
        rd_reg(4);
        chk("race_status", rd_obs, 32'h1);
        chk("race_intrpt", {31'h0, irq_obs}, 32'h1);
        wr_reg(0, 32'h0);
        wr_reg(4, 32'h3);

        // unmapped and unselected addresses
        wr_reg(0, 32'h6);
        wr_reg(1, 32'd5);
        wr_reg(2, 32'd9);
        wr_reg(3, 32'd4);
        do_cycle(1'b0, BASE + 32'h14, 32'h0);
        chk("unmapped_read", rd_obs, 32'h0);
        do_cycle(1'b0, 32'h1100_0000, 32'h0);
        chk("unselected_read", rd_obs, 32'h0);
        do_cycle(1'b1, BASE + 32'h14, 32'hFFFF_FFFF);
        do_cycle(1'b1, 32'h1100_0000, 32'hFFFF_FFFF);
        do_cycle(1'b1, BASE + 32'h1C, 32'hFFFF_FFFF);
        exp_regs = '{32'h6, 32'd5, 32'd9, 32'd4, 32'h0};
        for (int i = 0; i < 5; i++) begin
            rd_reg(i);
            chk("unchanged_reg", rd_obs, exp_regs[i]);
        end

        // random bus traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic        w;
            logic [2:0]  o;
            logic [31:0] a;
            logic [31:0] d;
            w = ($urandom_range(0, 15) < 6);
            o = 3'($urandom_range(0, 7));
            d = $urandom;
            case (o)
                3'd0: d[0] = ($urandom_range(0, 3) != 0);
                3'd1: d[15:0] = 16'($urandom_range(0, 3));
                3'd2: d = 32'($urandom_range(0, 6));
                3'd3: d = 32'($urandom_range(0, 6));
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0)
                a = BASE ^ (32'h20 << $urandom_range(0, 26));
            else
                a = BASE | {27'h0, o, 2'b00} | 32'($urandom_range(0, 3));
            do_cycle(w, a, d);
        end

        // reset in the middle of counting
        wr_reg(0, 32'h0);
        wr_reg(4, 32'h3);
        wr_reg(1, 32'h0);
        wr_reg(2, 32'h0);
        wr_reg(3, 32'h0);
        wr_reg(0, 32'h7);
        wr_reg(0, 32'h4);
        wr_reg(2, 32'd100);
        wr_reg(3, 32'd7);
        wr_reg(0, 32'h7);
        rd_reg(3);
        chk("prereset_count", rd_obs, 32'd7);
        chk("prereset_intrpt", {31'h0, irq_obs}, 32'h1);
        iobus_addr = BASE + 32'hC;
        rst = 1'b1;
        #1;
        chk("async_reset_count", iobus_in, 32'h0);
        chk("async_reset_intrpt", {31'h0, intrpt}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_reg(3);
            chk("postreset_count", rd_obs, 32'h0);
        end
        rd_reg(4);
        chk("postreset_status", rd_obs, 32'h0);
        rd_reg(0);
        chk("postreset_ctrl", rd_obs, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
